// File: rtl/rdi_pkg.sv
// Shared RDI definitions: status encodings, FSM states and default limits.
// The timer controller imports the same package so both sides agree on encodings.
package rdi_pkg;

  localparam int STS_W          = 4;
  localparam int PM_MAX_NAK_DEF = 3;

  localparam logic [STS_W-1:0] STS_RESET     = 4'b0000;
  localparam logic [STS_W-1:0] STS_ACTIVE    = 4'b0001;
  localparam logic [STS_W-1:0] STS_L1        = 4'b0100;
  localparam logic [STS_W-1:0] STS_L2        = 4'b1000;
  localparam logic [STS_W-1:0] STS_LINKERROR = 4'b1010;

  typedef enum logic [2:0] {
    ST_RESET   = 3'd0,
    ST_ACTIVE  = 3'd1,
    ST_PM_WAIT = 3'd2,
    ST_L1      = 3'd3,
    ST_L2      = 3'd4,
    ST_LINKERR = 3'd5
  } pm_state_t;

endpackage

// File: rtl/rdi_pm_state_fsm.sv
// RDI power-management / LinkError state machine.
// Follows lp_state_req, reports pl_state_sts, runs the L1/L2 sideband handshake
// with NAK retry and timeout abort, and holds LinkError for its minimum time.
// Drives the timer controller start levels and consumes its timeouts.
module rdi_pm_state_fsm #(
  parameter int STS_W      = 4,
  parameter int PM_MAX_NAK = 3
) (
  input  logic             lclk,
  input  logic             sys_rst,
  input  logic [STS_W-1:0] i_lp_state_req,
  input  logic             i_link_up,
  input  logic             i_linkerror_req,
  input  logic             i_sb_pm_ack,
  input  logic             i_sb_pm_nak,
  input  logic             i_pm_timeout,
  input  logic             i_linkerror_timeout,
  output logic [STS_W-1:0] o_pl_state_sts,
  output logic             o_pm_timer_start,
  output logic             o_linkerror_timer_start,
  output logic             o_sb_pm_req,
  output logic             o_sb_pm_req_l2,
  output logic             o_pm_abort
);

  import rdi_pkg::*;

  localparam logic [STS_W-1:0] ENC_RESET  = STS_W'(STS_RESET);
  localparam logic [STS_W-1:0] ENC_ACTIVE = STS_W'(STS_ACTIVE);
  localparam logic [STS_W-1:0] ENC_L1     = STS_W'(STS_L1);
  localparam logic [STS_W-1:0] ENC_L2     = STS_W'(STS_L2);
  localparam logic [STS_W-1:0] ENC_LERR   = STS_W'(STS_LINKERROR);

  // Number of PM requests (first + retries) allowed before giving up on NAK.
  localparam logic [3:0] NAK_LIMIT = 4'(PM_MAX_NAK);

  pm_state_t  state;
  logic [2:0] nak_cnt;
  // Set by a retryable NAK: the timer is held off for one cycle, then the
  // request is re-sent together with the timer restart.
  logic       resend;

  logic req_active;
  logic req_l1;
  logic req_l2;

  assign req_active = (i_lp_state_req == ENC_ACTIVE);
  assign req_l1     = (i_lp_state_req == ENC_L1);
  assign req_l2     = (i_lp_state_req == ENC_L2);

  // Saturating 3-bit NAK counter increment.
  function automatic logic [2:0] nak_sat_inc(input logic [2:0] cnt);
    return (cnt == 3'd7) ? cnt : cnt + 3'd1;
  endfunction

  // Single-process FSM: state, NAK counter and every registered output.
  always_ff @(posedge lclk or posedge sys_rst) begin
    if (sys_rst) begin
      state                   <= ST_RESET;
      nak_cnt                 <= 3'd0;
      resend                  <= 1'b0;
      o_pl_state_sts          <= ENC_RESET;
      o_pm_timer_start        <= 1'b0;
      o_linkerror_timer_start <= 1'b0;
      o_sb_pm_req             <= 1'b0;
      o_sb_pm_req_l2          <= 1'b0;
      o_pm_abort              <= 1'b0;
    end else begin
      o_sb_pm_req <= 1'b0;
      o_pm_abort  <= 1'b0;

      if (i_linkerror_req) begin
        // LinkError overrides everything, from any state.
        state                   <= ST_LINKERR;
        o_pl_state_sts          <= ENC_LERR;
        nak_cnt                 <= 3'd0;
        resend                  <= 1'b0;
        o_pm_timer_start        <= 1'b0;
        o_linkerror_timer_start <= 1'b1;
      end else begin
        case (state)
          ST_RESET: begin
            if (req_active && i_link_up) begin
              state          <= ST_ACTIVE;
              o_pl_state_sts <= ENC_ACTIVE;
              nak_cnt        <= 3'd0;
            end
          end

          ST_ACTIVE: begin
            if (req_l1 || req_l2) begin
              state            <= ST_PM_WAIT;
              resend           <= 1'b0;
              o_sb_pm_req      <= 1'b1;
              o_sb_pm_req_l2   <= req_l2;
              o_pm_timer_start <= 1'b1;
            end
          end

          ST_PM_WAIT: begin
            if (i_sb_pm_ack) begin
              // ACK beats a simultaneous timeout; target comes from the latched request.
              state            <= o_sb_pm_req_l2 ? ST_L2 : ST_L1;
              o_pl_state_sts   <= o_sb_pm_req_l2 ? ENC_L2 : ENC_L1;
              o_pm_timer_start <= 1'b0;
              resend           <= 1'b0;
            end else if (i_pm_timeout) begin
              state            <= ST_ACTIVE;
              o_pm_abort       <= 1'b1;
              o_pm_timer_start <= 1'b0;
              nak_cnt          <= 3'd0;
              resend           <= 1'b0;
            end else if (i_sb_pm_nak) begin
              if ({1'b0, nak_cnt} + 4'd1 < NAK_LIMIT) begin
                nak_cnt          <= nak_sat_inc(nak_cnt);
                o_pm_timer_start <= 1'b0;
                resend           <= 1'b1;
              end else begin
                state            <= ST_ACTIVE;
                o_pm_abort       <= 1'b1;
                o_pm_timer_start <= 1'b0;
                nak_cnt          <= 3'd0;
                resend           <= 1'b0;
              end
            end else if (req_active) begin
              // Adapter withdrew the request: quiet return, no abort.
              state            <= ST_ACTIVE;
              o_pm_timer_start <= 1'b0;
              nak_cnt          <= 3'd0;
              resend           <= 1'b0;
            end else if (resend) begin
              o_sb_pm_req      <= 1'b1;
              o_pm_timer_start <= 1'b1;
              resend           <= 1'b0;
            end
          end

          ST_L1: begin
            if (req_active && i_link_up) begin
              state          <= ST_ACTIVE;
              o_pl_state_sts <= ENC_ACTIVE;
              nak_cnt        <= 3'd0;
            end
          end

          ST_L2: begin
            // Leaving L2 always goes through a full retrain.
            if (req_active) begin
              state          <= ST_RESET;
              o_pl_state_sts <= ENC_RESET;
            end
          end

          ST_LINKERR: begin
            if (i_linkerror_timeout) begin
              state                   <= ST_RESET;
              o_pl_state_sts          <= ENC_RESET;
              o_linkerror_timer_start <= 1'b0;
            end else begin
              o_linkerror_timer_start <= 1'b1;
            end
          end

          default: begin
            state                   <= ST_RESET;
            o_pl_state_sts          <= ENC_RESET;
            o_pm_timer_start        <= 1'b0;
            o_linkerror_timer_start <= 1'b0;
            nak_cnt                 <= 3'd0;
            resend                  <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule
